// File: rtl/sprite_animator_if.sv
// Sprite ROM read port and palette write port of sprite_animator.
// Neither side has valid/ready flow control. The ROM is a fixed-latency
// synchronous read: rom_data belongs to the rom_addr seen one clock
// earlier. pal_we is a single-cycle write strobe qualifying pal_idx and
// pal_color on the same edge.
interface sprite_animator_if #(
  parameter int ADDR_BITS = 12,
  parameter int IDX_BITS  = 4
) ();
  logic [ADDR_BITS-1:0] rom_addr;
  logic [IDX_BITS-1:0]  rom_data;
  logic                 pal_we;
  logic [IDX_BITS-1:0]  pal_idx;
  logic [5:0]           pal_color;

  // Engine side: drives the ROM address, receives ROM data and palette writes.
  modport master (
    output rom_addr,
    input  rom_data,
    input  pal_we,
    input  pal_idx,
    input  pal_color
  );

  // ROM / host side.
  modport slave (
    input  rom_addr,
    output rom_data,
    output pal_we,
    output pal_idx,
    output pal_color
  );
endinterface

// File: rtl/sprite_animator.sv
// VGA sprite engine: timing counters, sprite ROM addressing, palette
// lookup with transparent index 0, and a 3-cycle pixel pipeline driving
// the 8-bit VGA PMOD. The sprite is upscaled by 2^SCALE_BITS and its
// animation frame advances every FRAME_HOLD video frames.
// Optional feature macro: SPRITE_MOVE_EN (sprite bounces inside the
// visible area). Without it the sprite stays at (SPRITE_X0, SPRITE_Y0).
module sprite_animator #(
  parameter int H_PIXELS      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_PIXELS      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int SCALE_BITS    = 3,
  parameter int SPRITE_W      = 64,
  parameter int SPRITE_H      = 32,
  parameter int NUM_FRAMES    = 2,
  parameter int FRAME_HOLD    = 16,
  parameter int IDX_BITS      = 4,
  parameter int SPRITE_X0     = 0,
  parameter int SPRITE_Y0     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [5:0]          bg_color,
  sprite_animator_if.master   bus,
  output logic                frame_start,
  output logic [7:0]          vga_pmod
);
  localparam int HT    = H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int VT    = V_PIXELS + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int XW    = $clog2(HT);
  localparam int YW    = $clog2(VT);
  localparam int SWB   = $clog2(SPRITE_W);
  localparam int SHB   = $clog2(SPRITE_H);
  localparam int FB    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HB    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int AB    = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H);
  localparam int PAL_N = 2 ** IDX_BITS;

  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [HB-1:0]   r_hold;
  logic [FB-1:0]   r_anim;
  logic [XW-1:0]   w_pos_x;
  logic [YW-1:0]   w_pos_y;
  logic [XW-1:0]   w_dx;
  logic [YW-1:0]   w_dy;
  logic [XW-1:0]   w_relx;
  logic [YW-1:0]   w_rely;
  logic            w_in;
  logic            w_act;
  logic            w_hs;
  logic            w_vs;
  logic            w_upd;
  logic [AB-1:0]   w_addr;
  logic [AB-1:0]   r_addr;
  logic            r_in1, r_act1, r_hs1, r_vs1;
  logic [5:0]      r_bg1;
  logic            r_in2, r_act2, r_hs2, r_vs2;
  logic [5:0]      r_bg2;
  logic [5:0]      w_color;
  logic [7:0]      r_pmod;
  logic [5:0]      r_pal [PAL_N];

  // Pixel and line counters; timing runs regardless of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_x == XW'(HT - 1)) begin
      r_x <= '0;
      r_y <= (r_y == YW'(VT - 1)) ? '0 : r_y + 1'b1;
    end else begin
      r_x <= r_x + 1'b1;
    end
  end

  assign frame_start = (r_x == '0) && (r_y == '0);

  // First vblank line start is the only point where motion/animation move.
  assign w_upd = enable && (r_x == '0) && (r_y == YW'(V_PIXELS));

  // Animation hold counter and frame index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_anim <= '0;
    end else if (w_upd) begin
      if (r_hold == HB'(FRAME_HOLD - 1)) begin
        r_hold <= '0;
        r_anim <= (r_anim == FB'(NUM_FRAMES - 1)) ? '0 : r_anim + 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

`ifdef SPRITE_MOVE_EN
  localparam int XMAX = H_PIXELS / (2 ** SCALE_BITS) - SPRITE_W;
  localparam int YMAX = V_PIXELS / (2 ** SCALE_BITS) - SPRITE_H;
  logic [XW-1:0] r_pos_x;
  logic [YW-1:0] r_pos_y;
  logic          r_dir_x;  // 1 = moving towards larger coordinates
  logic          r_dir_y;

  // Bouncing position: at a bound the direction flips and the step goes away from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos_x <= XW'(SPRITE_X0);
      r_pos_y <= YW'(SPRITE_Y0);
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (w_upd) begin
      if (XMAX == 0) begin
        r_pos_x <= '0;
      end else if (r_dir_x) begin
        if (r_pos_x >= XW'(XMAX)) begin
          r_pos_x <= XW'(XMAX - 1);
          r_dir_x <= 1'b0;
        end else begin
          r_pos_x <= r_pos_x + 1'b1;
        end
      end else if (r_pos_x == '0) begin
        r_pos_x <= XW'(1);
        r_dir_x <= 1'b1;
      end else begin
        r_pos_x <= r_pos_x - 1'b1;
      end

      if (YMAX == 0) begin
        r_pos_y <= '0;
      end else if (r_dir_y) begin
        if (r_pos_y >= YW'(YMAX)) begin
          r_pos_y <= YW'(YMAX - 1);
          r_dir_y <= 1'b0;
        end else begin
          r_pos_y <= r_pos_y + 1'b1;
        end
      end else if (r_pos_y == '0) begin
        r_pos_y <= YW'(1);
        r_dir_y <= 1'b1;
      end else begin
        r_pos_y <= r_pos_y - 1'b1;
      end
    end
  end

  assign w_pos_x = r_pos_x;
  assign w_pos_y = r_pos_y;
`else
  assign w_pos_x = XW'(SPRITE_X0);
  assign w_pos_y = YW'(SPRITE_Y0);
`endif

  // Sprite-space coordinates; the >= guards stop negative offsets aliasing.
  assign w_dx   = r_x >> SCALE_BITS;
  assign w_dy   = r_y >> SCALE_BITS;
  assign w_relx = w_dx - w_pos_x;
  assign w_rely = w_dy - w_pos_y;
  assign w_in   = (w_dx >= w_pos_x) && (w_relx < XW'(SPRITE_W)) &&
                  (w_dy >= w_pos_y) && (w_rely < YW'(SPRITE_H));
  assign w_addr = AB'({r_anim, w_rely[SHB-1:0], w_relx[SWB-1:0]});
  assign w_act  = (r_x < XW'(H_PIXELS)) && (r_y < YW'(V_PIXELS));
  assign w_hs   = !((r_x >= XW'(H_PIXELS + H_FRONT_PORCH)) &&
                    (r_x <  XW'(H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE)));
  assign w_vs   = !((r_y >= YW'(V_PIXELS + V_FRONT_PORCH)) &&
                    (r_y <  YW'(V_PIXELS + V_FRONT_PORCH + V_SYNC_PULSE)));

  // Stage 1: ROM address (held outside the sprite) plus pixel attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_in1  <= 1'b0;
      r_act1 <= 1'b0;
      r_bg1  <= '0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
    end else begin
      if (w_in) r_addr <= w_addr;
      r_in1  <= w_in;
      r_act1 <= w_act;
      r_bg1  <= bg_color;
      r_hs1  <= w_hs;
      r_vs1  <= w_vs;
    end
  end

  assign bus.rom_addr = r_addr;

  // Stage 2: attributes wait alongside the ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in2  <= 1'b0;
      r_act2 <= 1'b0;
      r_bg2  <= '0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
    end else begin
      r_in2  <= r_in1;
      r_act2 <= r_act1;
      r_bg2  <= r_bg1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  // Palette registers; index 0 is transparent and never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) r_pal[i] <= '0;
    end else if (bus.pal_we && (bus.pal_idx != '0)) begin
      r_pal[bus.pal_idx] <= bus.pal_color;
    end
  end

  // Colour select; a same-cycle palette write is seen only from the next lookup.
  always_comb begin
    w_color = '0;
    if (r_act2) begin
      if (r_in2 && (bus.rom_data != '0)) w_color = r_pal[bus.rom_data];
      else                               w_color = r_bg2;
    end
  end

  // Stage 3: registered PMOD output {hs,b0,g0,r0,vs,b1,g1,r1}.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pmod <= 8'b1000_1000;
    end else begin
      r_pmod <= {r_hs2, w_color[0], w_color[2], w_color[4],
                 r_vs2, w_color[1], w_color[3], w_color[5]};
    end
  end

  assign vga_pmod = r_pmod;
endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: a reduced-timing instance checked pixel by
// pixel against a frame-level reference model through an expected queue,
// plus a default-parameter instance checked for line timing.
module tb_sprite_animator;
  localparam int HP = 32, HFP = 4, HS = 8, HBP = 4;
  localparam int VP = 24, VFP = 2, VS = 2, VBP = 4;
  localparam int SB = 1, SW = 8, SH = 4, NF = 2, FH = 3, IB = 4;
  localparam int X0 = 2, Y0 = 3;
  localparam int HT = HP + HFP + HS + HBP;
  localparam int VT = VP + VFP + VS + VBP;
  localparam int AB = 6;
  localparam int FRAME_CYC = HT * VT;
  localparam int NCYC = 12 * FRAME_CYC;
`ifdef SPRITE_MOVE_EN
  localparam int XMAX = HP / (2 ** SB) - SW;
  localparam int YMAX = VP / (2 ** SB) - SH;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       enable = 1'b0;
  logic [5:0] bg_color = '0;
  logic       frame_start;
  logic [7:0] vga_pmod;
  logic       fs_d;
  logic [7:0] pmod_d;

  sprite_animator_if #(.ADDR_BITS(AB), .IDX_BITS(IB)) bus ();
  sprite_animator_if bus_d ();

  sprite_animator #(
    .H_PIXELS(HP), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HBP),
    .V_PIXELS(VP), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VBP),
    .SCALE_BITS(SB), .SPRITE_W(SW), .SPRITE_H(SH), .NUM_FRAMES(NF),
    .FRAME_HOLD(FH), .IDX_BITS(IB), .SPRITE_X0(X0), .SPRITE_Y0(Y0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .bg_color(bg_color),
    .bus(bus), .frame_start(frame_start), .vga_pmod(vga_pmod)
  );

  sprite_animator dut_d (
    .clk(clk), .rst(rst), .enable(1'b1), .bg_color(6'b000111),
    .bus(bus_d), .frame_start(fs_d), .vga_pmod(pmod_d)
  );
  assign bus_d.rom_data  = '0;
  assign bus_d.pal_we    = 1'b0;
  assign bus_d.pal_idx   = '0;
  assign bus_d.pal_color = '0;

  // Sprite ROM model: synchronous read.
  logic [IB-1:0] rom_m [NF*SW*SH];
  always @(posedge clk) bus.rom_data <= rom_m[bus.rom_addr];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]    exp_q[$];
  int            due_q[$];
  logic [AB-1:0] aexp_q[$];
  int            adue_q[$];
  int            cur_cyc = 0;
  bit            running = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cur_cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         act;
    bit         in_s;
    bit         hs;
    bit         vs;
    logic [5:0] bg;
    int         idx;
  } pix_t;
  pix_t pix_q[$];

  logic [5:0] pal_m [16];
  int mx, my, m_anim, m_hold, m_px, m_py, m_dirx, m_diry;

  function automatic logic [7:0] pack(input bit hs, input bit vs, input logic [5:0] c);
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  // One bounce step along an axis: step by dir, reverse if that leaves [0,max].
  task automatic bounce(inout int pos, inout int dir, input int max);
    int nxt;
    if (max == 0) begin
      pos = 0;
    end else begin
      nxt = pos + dir;
      if (nxt > max || nxt < 0) begin
        dir = -dir;
        nxt = pos + dir;
      end
      pos = nxt;
    end
  endtask

  // ---------------- driver + model ----------------
  initial begin
    pix_t       rec;
    pix_t       old;
    logic [5:0] c;
    int         dxs, dys, a, frame_no;
    logic       we;
    logic [3:0] widx;
    logic [5:0] wcol;

    for (int i = 0; i < NF*SW*SH; i++) rom_m[i] = IB'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) pal_m[i] = '0;
    bus.pal_we = 1'b0; bus.pal_idx = '0; bus.pal_color = '0;
    mx = 0; my = 0; m_anim = 0; m_hold = 0; m_px = X0; m_py = Y0;
    m_dirx = 1; m_diry = 1;

    repeat (4) @(posedge clk);
    #1;
    check("reset_pmod", vga_pmod, 8'h88);
    check("reset_frame_start", frame_start, 1);
    check("reset_pmod_default", pmod_d, 8'h88);
    check("reset_frame_start_default", fs_d, 1);

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'h88);
      due_q.push_back(k);
    end
    running = 1'b1;

    while (cur_cyc < NCYC) begin
      // inputs for this cycle
      frame_no = cur_cyc / FRAME_CYC;
      if (frame_no < 5)      enable = 1'b1;
      else if (frame_no < 8) enable = 1'b0;
      else                   enable = 1'($urandom_range(0, 1));
      bg_color = 6'($urandom_range(0, 63));
      if (cur_cyc == 100 || cur_cyc == 2000) begin
        we = 1'b1; widx = 4'd0; wcol = 6'b111111;
      end else if (cur_cyc < FRAME_CYC) begin
        we = ($urandom_range(0, 3) == 0); widx = 4'($urandom_range(0, 15));
        wcol = 6'($urandom_range(0, 63));
      end else begin
        we = ($urandom_range(0, 15) == 0); widx = 4'($urandom_range(0, 15));
        wcol = 6'($urandom_range(0, 63));
      end
      bus.pal_we = we; bus.pal_idx = widx; bus.pal_color = wcol;

      // what this pixel should be, from the frame-level rules
      dxs = mx >> SB;
      dys = my >> SB;
      rec.act  = (mx < HP) && (my < VP);
      rec.in_s = (dxs >= m_px) && (dxs - m_px < SW) && (dys >= m_py) && (dys - m_py < SH);
      rec.hs   = !(mx >= HP + HFP && mx < HP + HFP + HS);
      rec.vs   = !(my >= VP + VFP && my < VP + VFP + VS);
      rec.bg   = bg_color;
      rec.idx  = 0;
      if (rec.in_s) begin
        a = m_anim * SW * SH + (dys - m_py) * SW + (dxs - m_px);
        rec.idx = int'(rom_m[a]);
        aexp_q.push_back(AB'(a));
        adue_q.push_back(cur_cyc + 1);
      end
      pix_q.push_back(rec);
      check("frame_start", frame_start, (mx == 0 && my == 0) ? 1 : 0);

      // palette lookup of pixel t-2 happens now, before this cycle's write
      if (pix_q.size() > 2) begin
        old = pix_q.pop_front();
        c = '0;
        if (old.act) c = (old.in_s && old.idx != 0) ? pal_m[old.idx] : old.bg;
        exp_q.push_back(pack(old.hs, old.vs, c));
        due_q.push_back(cur_cyc + 1);
      end

      if (we && widx != 0) pal_m[widx] = wcol;

      if (mx == 0 && my == VP && enable) begin
        m_hold++;
        if (m_hold == FH) begin
          m_hold = 0;
          m_anim = (m_anim + 1) % NF;
        end
`ifdef SPRITE_MOVE_EN
        bounce(m_px, m_dirx, XMAX);
        bounce(m_py, m_diry, YMAX);
`endif
      end

      mx++;
      if (mx == HT) begin
        mx = 0;
        my = (my + 1) % VT;
      end

      @(posedge clk);
      #1;
      cur_cyc++;
    end

    // default-size line timing, taken from the edge monitor below
    check("hsync_fall_cycle", hs_fall0, 659);
    check("hsync_rise_cycle", hs_rise0, 755);
    check("line_period", hs_fall1 - hs_fall0, 800);
    check("vsync_high_first_lines", vs_low_seen, 0);

    // reset in the middle of a frame
    running = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midframe_reset_pmod", vga_pmod, 8'h88);
    check("midframe_reset_frame_start", frame_start, 1);
    check("midframe_reset_rom_addr", bus.rom_addr, 0);
    check("midframe_reset_pmod_default", pmod_d, 8'h88);
    if (exp_q.size() > 4) check("scoreboard_drained", exp_q.size(), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (running) begin
      while (exp_q.size() > 0 && due_q[0] <= cur_cyc) begin
        if (due_q[0] < cur_cyc) check("pmod_missed_slot", due_q[0], cur_cyc);
        else                    check("vga_pmod", vga_pmod, exp_q[0]);
        exp_q.pop_front();
        due_q.pop_front();
      end
      while (aexp_q.size() > 0 && adue_q[0] <= cur_cyc) begin
        check("rom_addr", bus.rom_addr, aexp_q[0]);
        aexp_q.pop_front();
        adue_q.pop_front();
      end
    end
  end

  // Default-parameter instance: record hsync edges over the first lines.
  int hs_fall0 = -1, hs_fall1 = -1, hs_rise0 = -1;
  int vs_low_seen = 0;
  bit prev_hs = 1'b1;
  always @(negedge clk) begin
    if (running && cur_cyc < 1700) begin
      if (!pmod_d[3]) vs_low_seen = 1;
      if (pmod_d[7] != prev_hs) begin
        if (!pmod_d[7]) begin
          if (hs_fall0 < 0) hs_fall0 = cur_cyc;
          else if (hs_fall1 < 0) hs_fall1 = cur_cyc;
        end else if (hs_rise0 < 0) begin
          hs_rise0 = cur_cyc;
        end
      end
      prev_hs = pmod_d[7];
    end
  end
endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
- Parametrised VGA sprite engine, successor to the fixed two-frame bitmap generator.
- Generates VGA timing and fetches indices from an external synchronous sprite ROM holding NUM_FRAMES animation frames.
- Maps indices through a run-time-writable palette, with index 0 transparent.
- Drives the 8-bit VGA PMOD; the sprite is upscaled by 2^SCALE_BITS and animated every FRAME_HOLD video frames.

Parameters:
H_PIXELS, 640, active pixels per line
H_FRONT_PORCH, 16, h front porch clocks
H_SYNC_PULSE, 96, hsync low width
H_BACK_PORCH, 48, h back porch clocks
V_PIXELS, 480, active lines
V_FRONT_PORCH, 10, v front porch lines
V_SYNC_PULSE, 2, vsync low width
V_BACK_PORCH, 33, v back porch lines
SCALE_BITS, 3, upscale = 2^SCALE_BITS per axis
SPRITE_W, 64, sprite width in sprite pixels (power of 2)
SPRITE_H, 32, sprite height in sprite pixels (power of 2)
NUM_FRAMES, 2, animation frames stored in ROM (power of 2)
FRAME_HOLD, 16, video frames per animation frame (>=1)
IDX_BITS, 4, palette index width
SPRITE_X0, 0, reset sprite x, downscaled units
SPRITE_Y0, 16, reset sprite y, downscaled units

Ports:
clk  in  1  clock, pixel rate
rst  in  1  synchronous reset, active-high
enable  in  1  1 = animation/motion advance; timing always runs
bg_color  in  6  {r[1:0],g[1:0],b[1:0]} for active pixels not covered by sprite
rom_addr  out  ADDR_BITS=clog2(NUM_FRAMES*SPRITE_W*SPRITE_H)  sprite ROM address
rom_data  in  IDX_BITS  ROM data, valid one cycle after rom_addr is presented
pal_we  in  1  palette write strobe
pal_idx  in  IDX_BITS  palette write index
pal_color  in  6  palette write colour {r,g,b}
frame_start  out  1  high in every cycle the counters equal (0,0)
vga_pmod  out  8  {hsync,b[0],g[0],r[0],vsync,b[1],g[1],r[1]}

Behaviour:
- Counters:
  - pixel_x wraps at HT-1, where HT = sum of the H_* parameters.
  - pixel_y increments on each x wrap and wraps at VT-1 (VT = sum of the V_* parameters).
  - Reset: both counters 0.
- Sync decode:
  - hsync low for pixel_x in [H_PIXELS+H_FRONT_PORCH, +H_SYNC_PULSE).
  - vsync low for pixel_y in [V_PIXELS+V_FRONT_PORCH, +V_SYNC_PULSE).
  - Both are delayed 3 cycles to align with colour.
- Pipeline (3-cycle latency):
  - Cycle n: counters (x,y).
  - Edge n→n+1: register rom_addr, in_sprite, active, bg_color, syncs.
  - Edge n+1→n+2: ROM output.
  - Edge n+2→n+3: vga_pmod registered.
- Sprite coordinates, taking dx = x>>SCALE_BITS and dy = y>>SCALE_BITS:
  - in_sprite = dx - pos_x in [0,SPRITE_W) and dy - pos_y in [0,SPRITE_H); unsigned compares, no wrap-around aliasing.
  - rom_addr = anim*SPRITE_W*SPRITE_H + (dy-pos_y)*SPRITE_W + (dx-pos_x).
  - Outside the sprite, rom_addr holds its last value.
- Colour select:
  - Outside active area: 6'b0.
  - Active, outside sprite or rom_data==0: bg_color, as sampled at stage 1.
  - Otherwise: palette[rom_data].
- Palette:
  - 2^IDX_BITS × 6-bit registers, reset to 0.
  - pal_we writes on the edge; writes to index 0 are ignored.
  - A write and a same-cycle lookup of the same index → the old value is output; the new value is used from the next lookup.
- Update point is counters = (0, V_PIXELS), the first vblank line. Motion and animation state change only there, when enable=1.
- Animation:
  - hold counter 0..FRAME_HOLD-1.
  - At wrap, anim increments mod NUM_FRAMES.
  - Reset: hold=0, anim=0.
- enable=0: hold, anim, pos and dir are frozen; video continues.
- Reset mid-frame: all state returns to reset values on the next edge.
- Output reset value: vga_pmod = 8'b1000_1000 (syncs high, colour 0).
- Reset: frame_start = 1 after reset (counters 0).

Optional Feature:
SPRITE_MOVE_EN:
- Defined:
  - At each update point, pos_x moves ±1 per dir_x, bounded to [0, XMAX] with XMAX = H_PIXELS/2^SCALE_BITS - SPRITE_W.
  - pos_y moves ±1 per dir_y, bounded to [0, YMAX] with YMAX = V_PIXELS/2^SCALE_BITS - SPRITE_H.
  - At a bound: dir flips and pos steps away (e.g. +dir at XMAX → pos XMAX-1, dir −).
  - If XMAX = 0, pos_x stays at 0.
  - Reset: pos = (SPRITE_X0, SPRITE_Y0), dirs = +.
- Undefined: pos fixed at (SPRITE_X0, SPRITE_Y0); no direction state.

Test Plan:
- Reset, then run 2 lines →
  - vga_pmod = 0x88 during reset.
  - hsync falls at pixel_x = 656+3 and rises at 752+3 clocks into the line.
  - Line period 800 clocks; frame 525 lines; frame_start once per 420000 clocks.
- Counters at (0,128), pos = (0,16) →
  - rom_addr = 0 one cycle later.
  - rom_data = 5 with palette[5] = 6'b110000 → vga_pmod colour bits r = 2'b11, at +3 cycles.
- rom_data = 0 inside sprite, bg_color = 6'b000111 → output blue = 2'b11. Same pixel at x ≥ 640 → colour 0.
- FRAME_HOLD = 16, enable = 1 →
  - anim goes 0→1 after 16 update points and 1→0 after 32; rom_addr MSB follows.
  - enable = 0 for 5 frames → no change.
- SPRITE_MOVE_EN defined, pos_x = 16, dir + →
  - Next update: pos_x = 15, dir −.
  - pos_y = 28 → pos_y = 27.
  - Undefined: pos constant over 100 frames.
- pal_we to index 0 with pal_color = 6'b111111 → index-0 pixels still show bg_color. Write idx 3 and look up idx 3 in the same cycle → old value, then new value.
